// File: rtl/not_output_a_pkg.sv
// Shared constants for the operand-conditioning primitive: op encoding and default datapath width.
package not_output_a_pkg;

  localparam int unsigned DATAPATH_W = 8;

  localparam logic OP_PASS = 1'b0;
  localparam logic OP_INV  = 1'b1;

endpackage

// File: rtl/not_output_a_core.sv
// Combinational core: y = a when op is OP_PASS, y = ~a when op is OP_INV (no +1; carry-in lives in the adder).
module not_output_a_core
  import not_output_a_pkg::*;
#(
  parameter int unsigned WIDTH = DATAPATH_W
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic             op
);

  // XOR with op inverts each bit independently, or passes it through.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    assign y[i] = a[i] ^ op;
  end

endmodule

// File: rtl/not_output_a.sv
// Operand conditioner with a registered result and valid flag.
// Defining NOT_OUTPUT_A_BYPASS_EN gives the zero-latency combinational form (clk/rst unused).
module not_output_a
  import not_output_a_pkg::*;
#(
  parameter int unsigned WIDTH = DATAPATH_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic [WIDTH-1:0] a,
  input  logic             op,
  input  logic             in_valid
);

  logic [WIDTH-1:0] result;

  not_output_a_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .y  (result),
    .a  (a),
    .op (op)
  );

`ifdef NOT_OUTPUT_A_BYPASS_EN
  assign y       = result;
  assign y_valid = in_valid;

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`else
  // Reset wins over a simultaneous valid; y holds its value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= in_valid;
      if (in_valid) begin
        y <= result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_not_output_a.sv
// Self-checking bench for not_output_a at WIDTH 8, 32 and 1 (registered or bypass build).
module tb_not_output_a;
  import not_output_a_pkg::*;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  a8, y8;
  logic        op8, v8, yv8;
  logic [31:0] a32, y32;
  logic        op32, v32, yv32;
  logic [0:0]  a1, y1;
  logic        op1, v1, yv1;

  always #5 clk = ~clk;

  not_output_a #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .y(y8), .y_valid(yv8), .a(a8), .op(op8), .in_valid(v8)
  );
  not_output_a #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .y(y32), .y_valid(yv32), .a(a32), .op(op32), .in_valid(v32)
  );
  not_output_a #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .y(y1), .y_valid(yv1), .a(a1), .op(op1), .in_valid(v1)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] a;
    logic       op;
    logic [7:0] ey;
    logic       ev;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        v;
  } exp_t;

  vec_t tbl[13];
  exp_t q8[$];
  exp_t q32[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic op, input logic [31:0] ey, input string name);
    exp_t e;
    @(negedge clk);
    a32 = a; op32 = op; v32 = 1'b1;
    q32.push_back('{ey, 1'b1});
`ifdef NOT_OUTPUT_A_BYPASS_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
    e = q32.pop_front();
    check({name, "_y"}, y32, e.y);
    check({name, "_valid"}, 32'(yv32), 32'(e.v));
  endtask

  task automatic run1(input logic a, input logic op, input logic ey, input string name);
    exp_t e;
    @(negedge clk);
    a1 = a; op1 = op; v1 = 1'b1;
    q1.push_back('{32'(ey), 1'b1});
`ifdef NOT_OUTPUT_A_BYPASS_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
    e = q1.pop_front();
    check({name, "_y"}, 32'(y1), e.y);
    check({name, "_valid"}, 32'(yv1), 32'(e.v));
  endtask

  initial begin
    exp_t e;
    //          rst   v     a      op       exp y  exp v
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, OP_PASS, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, OP_INV,  8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h04, OP_PASS, 8'h04, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'h04, OP_INV,  8'hFB, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, OP_INV,  8'hFF, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF, OP_INV,  8'h00, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h3C, OP_INV,  8'hC3, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h11, OP_PASS, 8'hC3, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'hE7, OP_INV,  8'hC3, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'hA5, OP_PASS, 8'hA5, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'h5A, OP_PASS, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h5A, OP_PASS, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h80, OP_INV,  8'h7F, 1'b1};

    rst = 1'b1;
    a8 = '0;  op8 = OP_PASS;  v8 = 1'b0;
    a32 = '0; op32 = OP_PASS; v32 = 1'b0;
    a1 = '0;  op1 = OP_PASS;  v1 = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; v8 = tbl[i].v; a8 = tbl[i].a; op8 = tbl[i].op;
`ifdef NOT_OUTPUT_A_BYPASS_EN
      // Combinational form: output follows the inputs with no edge, reset has no effect.
      q8.push_back('{32'(tbl[i].op ? ~tbl[i].a : tbl[i].a), tbl[i].v});
      #1;
`else
      q8.push_back('{32'(tbl[i].ey), tbl[i].ev});
      @(posedge clk);
      #1;
`endif
      e = q8.pop_front();
      check($sformatf("w8_row%0d_y", i), 32'(y8), e.y);
      check($sformatf("w8_row%0d_valid", i), 32'(yv8), 32'(e.v));
    end

    @(negedge clk);
    rst = 1'b0; v8 = 1'b0;

`ifdef NOT_OUTPUT_A_BYPASS_EN
    @(negedge clk);
    a8 = 8'h55; op8 = OP_INV; v8 = 1'b1;
    #1;
    check("bypass_55_y", 32'(y8), 32'h0000_00AA);
    check("bypass_valid_hi", 32'(yv8), 32'd1);
    v8 = 1'b0;
    #1;
    check("bypass_valid_lo", 32'(yv8), 32'd0);
`endif

    run32(32'd4, OP_INV, 32'hFFFF_FFFB, "w32_inv4");
    run32(32'hA5A5_A5A5, OP_PASS, 32'hA5A5_A5A5, "w32_passA5");
    run32(32'h0000_0000, OP_INV, 32'hFFFF_FFFF, "w32_inv0");

    run1(1'b0, OP_INV, 1'b1, "w1_inv0");
    run1(1'b1, OP_INV, 1'b0, "w1_inv1");
    run1(1'b1, OP_PASS, 1'b1, "w1_pass1");

    @(negedge clk);
    v32 = 1'b0; v1 = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
